// File: rtl/devilwalk_sprite_fetch.sv
// Walking-devil sprite fetch: maps the VGA draw coordinate to a sprite ROM address
// and turns the ROM data into a 4-bit palette index with an opaque-pixel flag.
module devilwalk_sprite_fetch #(
  parameter int unsigned SPR_W           = 32,
  parameter int unsigned SPR_H           = 32,
  parameter int unsigned N_FRAMES        = 4,
  parameter int unsigned TICKS_PER_FRAME = 6,
  parameter logic [3:0]  TRANS_INDEX     = 4'd0,
  parameter int unsigned AW              = $clog2(SPR_W * SPR_H * N_FRAMES)
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        vsync,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [9:0]                  pos_x,
  input  logic [9:0]                  pos_y,
  input  logic                        walking,
  input  logic                        face_left,
  output logic [AW-1:0]               rom_addr,
  input  logic [3:0]                  rom_q,
  output logic [3:0]                  pal_index,
  output logic                        pix_valid,
  output logic [$clog2(N_FRAMES)-1:0] frame_sel
);

  localparam int unsigned FW = $clog2(N_FRAMES);
  localparam int unsigned TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int unsigned XW = $clog2(SPR_W);
  localparam int unsigned YW = $clog2(SPR_H);
  localparam int unsigned CW = 11;

  typedef enum logic {S_IDLE, S_WALK} state_t;

  state_t        r_state;
  logic          r_vsync_d;
  logic          r_armed;
  logic          r_mirror;
  logic [TW-1:0] r_tick;
  logic [FW-1:0] r_frame;
  logic          r_in_box_d1;
  logic          r_in_box_d2;
  logic [AW-1:0] r_rom_addr;

  logic          w_vs_rise;
  logic [CW-1:0] w_x, w_y, w_px, w_py, w_px_end, w_py_end;
  logic          w_in_box;
  logic [XW-1:0] w_rel_x, w_col;
  logic [YW-1:0] w_rel_y;
  logic [AW-1:0] w_addr;

  // r_armed masks the level of a vsync that is already high when reset releases
  assign w_vs_rise = vsync & ~r_vsync_d & r_armed;

  // Animation state; frame and mirror only move on frame boundaries
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vsync_d <= 1'b0;
      r_armed   <= 1'b0;
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_frame   <= '0;
      r_mirror  <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      r_armed   <= 1'b1;
      if (w_vs_rise) begin
        r_mirror <= face_left;
        case (r_state)
          S_IDLE: begin
            r_frame <= '0;
            r_tick  <= '0;
            if (walking) r_state <= S_WALK;
          end
          S_WALK: begin
            if (!walking) begin
              r_state <= S_IDLE;
              r_frame <= '0;
              r_tick  <= '0;
            end else if (r_tick == TW'(TICKS_PER_FRAME - 1)) begin
              r_tick  <= '0;
              r_frame <= (r_frame == FW'(N_FRAMES - 1)) ? '0 : r_frame + FW'(1);
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Box test in 11 bits so a sprite near the right/bottom edge cannot wrap around
  assign w_x      = {1'b0, DrawX};
  assign w_y      = {1'b0, DrawY};
  assign w_px     = {1'b0, pos_x};
  assign w_py     = {1'b0, pos_y};
  assign w_px_end = w_px + CW'(SPR_W);
  assign w_py_end = w_py + CW'(SPR_H);
  assign w_in_box = (w_x >= w_px) && (w_x < w_px_end) && (w_y >= w_py) && (w_y < w_py_end);

  assign w_rel_x = XW'(DrawX - pos_x);
  assign w_rel_y = YW'(DrawY - pos_y);
  assign w_col   = r_mirror ? (XW'(SPR_W - 1) - w_rel_x) : w_rel_x;
  assign w_addr  = AW'(r_frame) * AW'(SPR_W * SPR_H) + AW'(w_rel_y) * AW'(SPR_W) + AW'(w_col);

  // Two-stage pixel pipeline aligned with the 1-cycle ROM read
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rom_addr  <= '0;
      r_in_box_d1 <= 1'b0;
      r_in_box_d2 <= 1'b0;
    end else begin
      r_rom_addr  <= w_in_box ? w_addr : '0;
      r_in_box_d1 <= w_in_box;
      r_in_box_d2 <= r_in_box_d1;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign frame_sel = r_frame;
  assign pix_valid = r_in_box_d2 & (rom_q != TRANS_INDEX);
  assign pal_index = pix_valid ? rom_q : TRANS_INDEX;

endmodule

// File: tb/tb_devilwalk_sprite_fetch.sv
// Scoreboard bench for devilwalk_sprite_fetch: directed pixels push expected ROM
// addresses and palette outputs; a monitor pops and compares them at the right stage.
module tb_devilwalk_sprite_fetch;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       vsync;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       walking, face_left;
  logic [11:0] rom_addr;
  logic [3:0] rom_q = 4'd0;
  logic [3:0] pal_index;
  logic       pix_valid;
  logic [1:0] frame_sel;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  mem [4096];
  logic [11:0] q_addr[$];
  logic [4:0]  q_pix[$];
  logic        issue = 1'b0;

  devilwalk_sprite_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .vsync(vsync),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
    .walking(walking), .face_left(face_left),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .pal_index(pal_index), .pix_valid(pix_valid), .frame_sel(frame_sel)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM model: contents are (addr*7+5) mod 16
  initial for (int a = 0; a < 4096; a++) mem[a] = 4'((a * 7 + 5) % 16);
  always @(posedge Clk) rom_q <= mem[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one pixel for one cycle (called at negedge)
  task automatic pix(input int x, input int y, input int a, input bit v, input int idx);
    DrawX = 10'(x);
    DrawY = 10'(y);
    issue = 1'b1;
    q_addr.push_back(12'(a));
    q_pix.push_back({v, 4'(idx)});
    @(negedge Clk);
    issue = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    @(negedge Clk);
    vsync = 1'b0;
    @(negedge Clk);
  endtask

  // Monitor: stage-1 marker checks rom_addr, stage-2 marker checks palette outputs
  initial begin : monitor
    logic s1, s2;
    logic [11:0] ea;
    logic [4:0]  ep;
    s1 = 1'b0;
    s2 = 1'b0;
    forever begin
      @(posedge Clk);
      s2 = s1;
      s1 = issue;
      #1;
      if (s1) begin
        if (q_addr.size() == 0) chk("addr_queue_empty", 1, 0);
        else begin
          ea = q_addr.pop_front();
          chk("rom_addr", int'(rom_addr), int'(ea));
        end
      end
      if (s2) begin
        if (q_pix.size() == 0) chk("pix_queue_empty", 1, 0);
        else begin
          ep = q_pix.pop_front();
          chk("pix_valid", int'(pix_valid), int'(ep[4]));
          chk("pal_index", int'(pal_index), int'(ep[3:0]));
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q_pix.size() != 0) && (n < 20)) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_timeout", q_pix.size(), 0);
  endtask

  initial begin
    Reset_n = 1'b0; vsync = 1'b1; walking = 1'b0; face_left = 1'b1;
    DrawX = '0; DrawY = '0; pos_x = 10'd100; pos_y = 10'd50;
    repeat (3) @(negedge Clk);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_frame_sel", int'(frame_sel), 0);

    // vsync high through reset release: no edge, so mirror must stay 0
    Reset_n = 1'b1;
    repeat (10) @(negedge Clk);
    chk("noedge_frame_sel", int'(frame_sel), 0);
    chk("noedge_pix_valid", int'(pix_valid), 0);
    chk("noedge_pal_index", int'(pal_index), 0);
    vsync = 1'b0; face_left = 1'b0;
    @(negedge Clk);

    // Basic in/out of box, facing right, frame 0
    pix(100, 50, 0, 1'b1, 5);
    pix(99, 50, 0, 1'b0, 0);
    pix(131, 81, 1023, 1'b1, 14);
    pix(132, 50, 0, 1'b0, 0);
    pix(100, 82, 0, 1'b0, 0);
    pix(113, 50, 13, 1'b0, 0);   // ROM returns transparent key
    drain();

    // Mirror latched by an edge; toggling face_left without an edge has no effect
    face_left = 1'b1;
    vs_pulse();
    face_left = 1'b0;
    pix(100, 51, 63, 1'b1, 14);
    pix(131, 51, 32, 1'b1, 5);
    drain();
    vs_pulse();

    // Walk cycle: edge 1 enters WALK, frame steps every 6 edges after that
    walking = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      vs_pulse();
      chk($sformatf("walk_frame_e%0d", e), int'(frame_sel), (e >= 7) ? ((e - 1) / 6) % 4 : 0);
      if (e == 13) begin
        pix(101, 50, 2049, 1'b1, 12);
        drain();
      end
    end
    walking = 1'b0;
    vs_pulse();
    chk("stop_frame_sel", int'(frame_sel), 0);

    // Right-edge and wrap-around boundaries
    pos_x = 10'd620;
    pix(639, 50, 19, 1'b1, 10);
    pix(0, 50, 0, 1'b0, 0);
    pos_x = 10'd1000;
    pix(5, 50, 0, 1'b0, 0);
    drain();

    // Asynchronous reset in the middle of WALK at frame 2
    pos_x = 10'd100;
    walking = 1'b1;
    repeat (13) vs_pulse();
    chk("pre_rst_frame_sel", int'(frame_sel), 2);
    DrawX = 10'd101; DrawY = 10'd50;
    repeat (3) @(negedge Clk);
    chk("pre_rst_rom_addr", int'(rom_addr), 2049);
    chk("pre_rst_pix_valid", int'(pix_valid), 1);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_frame_sel", int'(frame_sel), 0);
    chk("async_rom_addr", int'(rom_addr), 0);
    chk("async_pix_valid", int'(pix_valid), 0);
    chk("async_pal_index", int'(pal_index), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    walking = 1'b0;
    repeat (2) @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
